// File: rtl/seq_detector_1011_pkg.sv
`default_nettype none
// seq_detector_1011_pkg: state encoding shared by the 1-0-1-1 detector.
// Rev 1.0
package seq_detector_1011_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_detector_1011_sat_counter.sv
`default_nettype none
// sat_counter: W-bit up-counter that increments on INC and sticks at all-ones.
// Rev 1.0
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         INC,
  output logic [W-1:0] Q
);

  logic [W-1:0] cnt_q;
  logic         at_max_d;

  assign at_max_d = (cnt_q == {W{1'b1}});

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (INC && !at_max_d) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign Q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector_1011.sv
`default_nettype none
// seq_detector_1011: Moore detector for serial pattern 1-0-1-1 with saturating hit count.
// Rev 1.0
module seq_detector_1011
  import seq_detector_1011_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               DIN,
  input  logic               EN,
  output logic               DETECT,
  output logic [CNT_W-1:0]   COUNT,
  output logic [STATE_W-1:0] STATE
);

  state_t state_q;
  logic   detect_q;
  logic   hit_d;

  // A hit is the accepted 1 that completes 1-0-1-1; it feeds both the pulse and the counter.
  assign hit_d = EN && DIN && (state_q == S101);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S0;
      detect_q <= 1'b0;
    end else begin
      detect_q <= hit_d;
      case (state_q)
        S0:      if (EN) state_q <= DIN ? S1   : S0;
        S1:      if (EN) state_q <= DIN ? S1   : S10;
        S10:     if (EN) state_q <= DIN ? S101 : S0;
        S101:    if (EN) state_q <= DIN ? S1011 : S10;
        S1011:   if (EN) state_q <= DIN ? S1 : ((OVERLAP != 0) ? S10 : S0);
        default: state_q <= S0;
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .CLK (CLK),
    .RST (RST),
    .INC (hit_d),
    .Q   (COUNT)
  );

  assign DETECT = detect_q;
  assign STATE  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_1011.sv
`default_nettype none
// tb_seq_detector_1011: three detector variants against a history-based reference model.
// Rev 1.0
module tb_seq_detector_1011;

  logic       clk;
  logic       rst;
  logic       din;
  logic       en;
  logic       det0, det1, det2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [2:0] st0, st1, st2;

  int n_vec = 0;
  int n_err = 0;

  // Model: recent accepted bits (newest at bit 0) and how many are valid since the last restart.
  int ovl  [3] = '{1, 0, 1};
  int maxc [3] = '{255, 255, 3};
  int hist [3];
  int hlen [3];
  int m_st [3];
  int m_cnt[3];
  int m_det[3];

  seq_detector_1011 #(.OVERLAP(1), .CNT_W(8)) u_ov (
    .CLK(clk), .RST(rst), .DIN(din), .EN(en), .DETECT(det0), .COUNT(cnt0), .STATE(st0));
  seq_detector_1011 #(.OVERLAP(0), .CNT_W(8)) u_nov (
    .CLK(clk), .RST(rst), .DIN(din), .EN(en), .DETECT(det1), .COUNT(cnt1), .STATE(st1));
  seq_detector_1011 #(.OVERLAP(1), .CNT_W(2)) u_sat (
    .CLK(clk), .RST(rst), .DIN(din), .EN(en), .DETECT(det2), .COUNT(cnt2), .STATE(st2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Longest tail of the history that is a proper prefix of 1011 (prefix values 1, 10b, 101b).
  function automatic int progress(input int h, input int n);
    int pref[4] = '{0, 1, 2, 5};
    for (int k = 3; k >= 1; k--) begin
      if (n >= k && ((h & ((1 << k) - 1)) == pref[k])) return k;
    end
    return 0;
  endfunction

  task automatic step(input logic r, input logic e, input logic d);
    rst = r; en = e; din = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_det[i] = 0;
      if (r) begin
        hist[i] = 0; hlen[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
      end else if (e) begin
        hist[i] = ((hist[i] << 1) | int'(d)) & 15;
        if (hlen[i] < 4) hlen[i]++;
        if (hlen[i] == 4 && hist[i] == 11) begin
          m_det[i] = 1;
          m_st[i]  = 4;
          if (m_cnt[i] < maxc[i]) m_cnt[i]++;
          if (ovl[i] == 0) begin
            hist[i] = 0; hlen[i] = 0;
          end
        end else begin
          m_st[i] = progress(hist[i], hlen[i]);
        end
      end
    end
    chk("ov_detect",  32'(det0), 32'(m_det[0]));
    chk("ov_count",   32'(cnt0), 32'(m_cnt[0]));
    chk("ov_state",   32'(st0),  32'(m_st[0]));
    chk("nov_detect", 32'(det1), 32'(m_det[1]));
    chk("nov_count",  32'(cnt1), 32'(m_cnt[1]));
    chk("nov_state",  32'(st1),  32'(m_st[1]));
    chk("sat_detect", 32'(det2), 32'(m_det[2]));
    chk("sat_count",  32'(cnt2), 32'(m_cnt[2]));
    chk("sat_state",  32'(st2),  32'(m_st[2]));
  endtask

  task automatic send(input logic [15:0] bits, input int n, input int gap);
    for (int b = n - 1; b >= 0; b--) begin
      step(1'b0, 1'b1, bits[b]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    int hits;
    rst = 1'b1; en = 1'b0; din = 1'b0;

    for (int c = 0; c < 3; c++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("reset_state", 32'(st0), 32'd0);
    chk("reset_count", 32'(cnt0), 32'd0);

    send(16'b1011, 4, 0);
    chk("basic_detect", 32'(det0), 32'd1);
    chk("basic_count", 32'(cnt0), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("basic_pulse_end", 32'(det0), 32'd0);

    step(1'b1, 1'b0, 1'b0);
    send(16'b1011011, 7, 0);
    chk("overlap_count", 32'(cnt0), 32'd2);
    chk("nonoverlap_count", 32'(cnt1), 32'd1);

    step(1'b1, 1'b0, 1'b0);
    send(16'b1011, 4, 5);
    chk("en_gap_count", 32'(cnt0), 32'd1);

    step(1'b1, 1'b0, 1'b0);
    send(16'b10011, 5, 0);
    chk("near_miss_count", 32'(cnt0), 32'd0);
    chk("near_miss_state", 32'(st0), 32'd1);

    step(1'b1, 1'b0, 1'b0);
    send(16'b101, 3, 0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_mid_detect", 32'(det0), 32'd0);
    chk("rst_mid_count", 32'(cnt0), 32'd0);
    chk("rst_mid_state", 32'(st0), 32'd0);
    send(16'b1011, 4, 0);
    chk("after_rst_count", 32'(cnt0), 32'd1);

    step(1'b1, 1'b0, 1'b0);
    hits = 0;
    for (int p = 0; p < 5; p++) begin
      send(16'b1011, 4, 0);
      hits += int'(det2);
      chk("sat_count_seq", 32'(cnt2), 32'((p < 3) ? p + 1 : 3));
    end
    chk("sat_pulses", 32'(hits), 32'd5);

    for (int s = 0; s < 3000; s++) begin
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
